// File: rtl/alu_share_sched_if.sv
// Bundle of request, ALU and response signals for alu_share_sched.
// slave = scheduler side, master = requesters / ALU / consumer side.
interface alu_share_sched_if #(
  parameter int WIDTH = 4,
  parameter int CTRW  = 3
);
  // Every channel uses valid/ready: a transfer happens on a rising edge where
  // both are high; the offering side holds valid and payload until then.
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [CTRW-1:0]  req0_ctr;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [CTRW-1:0]  req1_ctr;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [CTRW-1:0]  alu_ctr;
  logic [WIDTH-1:0] alu_f;
  logic             alu_cf;
  logic             alu_zero;
  logic             alu_of;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_f;
  logic             rsp_cf;
  logic             rsp_zero;
  logic             rsp_of;
  logic             busy;
  logic [1:0]       state_dbg;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctr,
    input  req1_valid, req1_a, req1_b, req1_ctr,
    input  alu_f, alu_cf, alu_zero, alu_of, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_ctr,
    output rsp_valid, rsp_id, rsp_f, rsp_cf, rsp_zero, rsp_of, busy, state_dbg
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctr,
    output req1_valid, req1_a, req1_b, req1_ctr,
    output alu_f, alu_cf, alu_zero, alu_of, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_ctr,
    input  rsp_valid, rsp_id, rsp_f, rsp_cf, rsp_zero, rsp_of, busy, state_dbg
  );
endinterface

// File: rtl/alu_share_sched.sv
// Two-requester scheduler time-sharing one external combinational ALU.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_share_sched #(
  parameter int WIDTH = 4,
  parameter int CTRW  = 3
) (
  input logic              clk,
  input logic              rst,
  alu_share_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [CTRW-1:0]  alu_ctr_q, alu_ctr_d;
  logic [WIDTH-1:0] rsp_f_q, rsp_f_d;
  logic             rsp_cf_q, rsp_cf_d, rsp_zero_q, rsp_zero_d, rsp_of_q, rsp_of_d;
  logic             gnt_valid, gnt_id, accept;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt_valid = bus.req0_valid | bus.req1_valid;
    gnt_id    = ~bus.req0_valid;
  end
`else
  logic last_grant_q;

  // On a tie the requester not served last time wins.
  always_comb begin
    gnt_valid = bus.req0_valid | bus.req1_valid;
    gnt_id    = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : ~bus.req0_valid;
  end

  always_ff @(posedge clk) begin
    if (rst)         last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= gnt_id;
  end
`endif

  // Readys are masked during reset so no handshake can coincide with it.
  assign accept         = (state_q == IDLE) && gnt_valid && !rst;
  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept && gnt_id;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctr_d  = alu_ctr_q;
    rsp_f_d    = rsp_f_q;
    rsp_cf_d   = rsp_cf_q;
    rsp_zero_d = rsp_zero_q;
    rsp_of_d   = rsp_of_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = EXEC;
          id_d      = gnt_id;
          alu_a_d   = gnt_id ? bus.req1_a   : bus.req0_a;
          alu_b_d   = gnt_id ? bus.req1_b   : bus.req0_b;
          alu_ctr_d = gnt_id ? bus.req1_ctr : bus.req0_ctr;
        end
      end
      EXEC: begin
        state_d    = RESP;
        rsp_f_d    = bus.alu_f;
        rsp_cf_d   = bus.alu_cf;
        rsp_zero_d = bus.alu_zero;
        rsp_of_d   = bus.alu_of;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctr_q  <= '0;
      rsp_f_q    <= '0;
      rsp_cf_q   <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_of_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctr_q  <= alu_ctr_d;
      rsp_f_q    <= rsp_f_d;
      rsp_cf_q   <= rsp_cf_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_of_q   <= rsp_of_d;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_ctr   = alu_ctr_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_f     = rsp_f_q;
  assign bus.rsp_cf    = rsp_cf_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_of    = rsp_of_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_alu_share_sched.sv
// Self-checking bench for alu_share_sched: transaction-level model plus a stand-in ALU.
module tb_alu_share_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_sched_if #(.WIDTH(4), .CTRW(3)) bus();

  alu_share_sched #(.WIDTH(4), .CTRW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for the external ALU: returns {F, cf, zero, of}.
  function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] c);
    logic [4:0] s;
    logic [3:0] f;
    logic       cf, of;
    s = '0; f = '0; cf = 1'b0; of = 1'b0;
    case (c)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; f = s[3:0]; cf = s[4];
                  of = (a[3] == b[3]) && (f[3] != a[3]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; f = s[3:0]; cf = s[4];
                  of = (a[3] != b[3]) && (f[3] != a[3]); end
      3'd2: f = a & b;
      3'd3: f = a | b;
      3'd4: f = a ^ b;
      3'd5: f = ~(a | b);
      3'd6: f = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: f = b;
    endcase
    return {f, cf, (f == 4'd0), of};
  endfunction

  assign {bus.alu_f, bus.alu_cf, bus.alu_zero, bus.alu_of} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctr);

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stimulus state: pending requests are held until accepted.
  logic       rst_r;
  bit         p0v, p1v, rsp_rdy;
  logic [3:0] p0a, p0b, p1a, p1b;
  logic [2:0] p0c, p1c;
  int         refill_pct, rr_pct;

  // Reference model: one operation in flight, response two cycles after accept.
  bit         m_idle = 1'b1;
  bit         m_last = 1'b1;
  int         m_age;
  logic [3:0] m_a = '0, m_b = '0;
  logic [2:0] m_c = '0;
  logic [7:0] exp_q[$];
  int         grant_log[$];
  bit         was_rst;

  task automatic refill();
    if (!p0v && $urandom_range(0, 99) < refill_pct) begin
      p0v = 1'b1; p0a = 4'($urandom); p0b = 4'($urandom); p0c = 3'($urandom);
    end
    if (!p1v && $urandom_range(0, 99) < refill_pct) begin
      p1v = 1'b1; p1a = 4'($urandom); p1b = 4'($urandom); p1c = 3'($urandom);
    end
  endtask

  task automatic run_cycle();
    bit         acc, g;
    logic [7:0] e;
    acc = 1'b0; g = 1'b0;
    rst = rst_r;
    bus.req0_valid = p0v; bus.req0_a = p0a; bus.req0_b = p0b; bus.req0_ctr = p0c;
    bus.req1_valid = p1v; bus.req1_a = p1a; bus.req1_b = p1b; bus.req1_ctr = p1c;
    bus.rsp_ready  = rsp_rdy;
    #2;
    if (was_rst) begin
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_id", bus.rsp_id, 0);
      check("rst_rsp_fields", {bus.rsp_f, bus.rsp_cf, bus.rsp_zero, bus.rsp_of}, 0);
      check("rst_alu_regs", {bus.alu_a, bus.alu_b, bus.alu_ctr}, 0);
      check("rst_busy", bus.busy, 0);
    end
    if (rst_r) begin
      check("rdy0_in_rst", bus.req0_ready, 0);
      check("rdy1_in_rst", bus.req1_ready, 0);
    end else if (m_idle) begin
      if (p0v || p1v) begin
        acc = 1'b1;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        g = !p0v;
`else
        g = (p0v && p1v) ? !m_last : !p0v;
`endif
      end
      check("rdy0", bus.req0_ready, acc && !g);
      check("rdy1", bus.req1_ready, acc && g);
      check("idle_busy", bus.busy, 0);
      check("idle_rsp_valid", bus.rsp_valid, 0);
      check("idle_alu_hold", {bus.alu_a, bus.alu_b, bus.alu_ctr}, {m_a, m_b, m_c});
      if (acc) begin
        m_a = g ? p1a : p0a; m_b = g ? p1b : p0b; m_c = g ? p1c : p0c;
        exp_q.push_back({g, alu_fn(m_a, m_b, m_c)});
        grant_log.push_back(int'(g));
        m_last = g; m_idle = 1'b0; m_age = 0;
      end
    end else begin
      m_age++;
      check("busy_rdy0", bus.req0_ready, 0);
      check("busy_rdy1", bus.req1_ready, 0);
      check("busy", bus.busy, 1);
      check("alu_regs", {bus.alu_a, bus.alu_b, bus.alu_ctr}, {m_a, m_b, m_c});
      check("rsp_valid", bus.rsp_valid, m_age >= 2);
      if (m_age >= 2 && exp_q.size() > 0) begin
        e = exp_q[0];
        check("rsp_id", bus.rsp_id, e[7]);
        check("rsp_fields", {bus.rsp_f, bus.rsp_cf, bus.rsp_zero, bus.rsp_of}, e[6:0]);
        if (rsp_rdy) begin
          void'(exp_q.pop_front());
          m_idle = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    if (acc) begin
      if (g) p1v = 1'b0; else p0v = 1'b0;
    end
    was_rst = rst_r;
    if (rst_r) begin
      m_idle = 1'b1; m_last = 1'b1; m_a = '0; m_b = '0; m_c = '0;
      exp_q.delete();
    end
  endtask

  task automatic drain();
    p0v = 1'b0; p1v = 1'b0; rsp_rdy = 1'b1;
    for (int i = 0; i < 10 && !m_idle; i++) run_cycle();
    check("drain_idle", m_idle, 1);
  endtask

  initial begin
    int exp_g[4];
    rst_r = 1'b1; rsp_rdy = 1'b1; refill_pct = 100; rr_pct = 100;
    p0v = 1'b1; p0a = 4'd1; p0b = 4'd2; p0c = 3'd0;
    p1v = 1'b1; p1a = 4'd3; p1b = 4'd4; p1c = 3'd2;
    rst = 1'b1;
    @(posedge clk); #1;
    was_rst = 1'b1;

    // Reset with both requesters valid, then continuous contention.
    repeat (2) run_cycle();
    rst_r = 1'b0;
    grant_log.delete();
    repeat (12) begin refill(); run_cycle(); end
`ifdef ALU_SCHED_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    check("contention_count", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4)
      for (int i = 0; i < 4; i++) check("contention_grant", grant_log[i], exp_g[i]);
    drain();

    // Single request.
    p0v = 1'b1; p0a = 4'b0101; p0b = 4'b1010; p0c = 3'd3;
    run_cycle();
    check("single_alu_a", bus.alu_a, 4'b0101);
    check("single_alu_ctr", bus.alu_ctr, 3'd3);
    repeat (3) run_cycle();
    drain();

    // Backpressure: response held five cycles while requester 1 waits.
    p0v = 1'b1; p0a = 4'($urandom); p0b = 4'($urandom); p0c = 3'($urandom);
    run_cycle();
    p1v = 1'b1; p1a = 4'($urandom); p1b = 4'($urandom); p1c = 3'($urandom);
    rsp_rdy = 1'b0;
    repeat (6) run_cycle();
    rsp_rdy = 1'b1;
    run_cycle();
    run_cycle();
    check("bp_req1_taken", p1v, 0);
    drain();

    // Reset while the operation is in EXEC.
    p0v = 1'b1; p0a = 4'b1000; p0b = 4'b1000; p0c = 3'd0;
    run_cycle();
    rst_r = 1'b1; run_cycle(); rst_r = 1'b0;
    repeat (4) run_cycle();
    check("midrst_state", bus.state_dbg, 0);

    // Operand change after accept must not reach the ALU.
    p0v = 1'b1; p0a = 4'b1111; p0b = 4'($urandom); p0c = 3'($urandom);
    run_cycle();
    p0a = 4'b0000;
    repeat (2) run_cycle();
    check("indep_alu_a", bus.alu_a, 4'b1111);
    drain();

    // Randomized traffic.
    refill_pct = 50; rr_pct = 60;
    repeat (400) begin
      refill();
      rsp_rdy = ($urandom_range(0, 99) < rr_pct);
      run_cycle();
    end
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
